// File: rtl/sayeh_ctrl_pkg.sv
// SAYEH control package
// State encoding and half-select constants for the fetch sequencer.
package sayeh_ctrl_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_ISHI  = 4'd3;
  localparam logic [3:0] ST_WTHI  = 4'd4;
  localparam logic [3:0] ST_ISLO  = 4'd5;
  localparam logic [3:0] ST_WTLO  = 4'd6;
  localparam logic [3:0] ST_ADV   = 4'd7;
  localparam logic [3:0] ST_HALT  = 4'd8;
  localparam logic [3:0] ST_ERR   = 4'd9;

  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_LOAD     = ST_LOAD,
    S_ISSUE_HI = ST_ISHI,
    S_WAIT_HI  = ST_WTHI,
    S_ISSUE_LO = ST_ISLO,
    S_WAIT_LO  = ST_WTLO,
    S_ADVANCE  = ST_ADV,
    S_HALT     = ST_HALT,
    S_ERROR    = ST_ERR
  } state_t;

endpackage

// File: rtl/ir_fetch_sequencer.sv
// SAYEH instruction fetch/issue sequencer
// Fetches a word, loads IR, issues upper then optional lower half.
module ir_fetch_sequencer
  import sayeh_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int BOOT_IDLE   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_ready,
  input  logic exec_done,
  input  logic ir_short,
  input  logic lo_nop,
  input  logic jump_taken,
  input  logic halt_req,
  output logic mem_read,
  output logic ir_load,
  output logic exec_start,
  output logic exec_half,
  output logic pc_inc,
  output logic halted,
  output logic bus_error
);

  localparam int CNT_MAX =
    (MEM_TIMEOUT > BOOT_IDLE) ? MEM_TIMEOUT : BOOT_IDLE;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW:0] TMO_LIM  = MEM_TIMEOUT[CW:0];
  localparam logic [CW:0] BOOT_LIM = BOOT_IDLE[CW:0];

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW:0]     w_cnt_inc;

  // Shared boot/timeout counter, one step ahead
  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    mem_read    = 1'b0;
    ir_load     = 1'b0;
    exec_start  = 1'b0;
    exec_half   = HALF_HI;
    pc_inc      = 1'b0;
    halted      = 1'b0;
    bus_error   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cnt_inc >= BOOT_LIM) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_cnt_nxt = w_cnt_inc[CW-1:0];
        end
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_LOAD;
        end else if (w_cnt_inc == TMO_LIM) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = w_cnt_inc[CW-1:0];
        end
      end
      S_LOAD: begin
        ir_load     = 1'b1;
        w_state_nxt = S_ISSUE_HI;
      end
      S_ISSUE_HI: begin
        exec_start  = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (exec_done) begin
          if (halt_req)              w_state_nxt = S_HALT;
          else if (jump_taken)       w_state_nxt = S_FETCH;
          else if (ir_short && !lo_nop)
                                     w_state_nxt = S_ISSUE_LO;
          else                       w_state_nxt = S_ADVANCE;
        end
      end
      S_ISSUE_LO: begin
        exec_start  = 1'b1;
        exec_half   = HALF_LO;
        w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        exec_half = HALF_LO;
        if (exec_done) begin
          if (halt_req)        w_state_nxt = S_HALT;
          else if (jump_taken) w_state_nxt = S_FETCH;
          else                 w_state_nxt = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        pc_inc      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALT:  halted    = 1'b1;
      S_ERROR: bus_error = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer
// Scoreboard of expected pulse order plus cycle-exact checks.
module tb_ir_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ready = 1'b0;
  logic exec_done = 1'b0;
  logic ir_short = 1'b0;
  logic lo_nop = 1'b0;
  logic jump_taken = 1'b0;
  logic halt_req = 1'b0;
  logic mem_read, ir_load, exec_start, exec_half;
  logic pc_inc, halted, bus_error;
  logic [6:0] outs;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int c_load, c_start, c_pc, c_end, n_start, n_pc;

  always #5 clk = ~clk;

  assign outs = {mem_read, ir_load, exec_start, exec_half,
                 pc_inc, halted, bus_error};

  ir_fetch_sequencer #(
    .MEM_TIMEOUT(15),
    .BOOT_IDLE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_ready(mem_ready),
    .exec_done(exec_done),
    .ir_short(ir_short),
    .lo_nop(lo_nop),
    .jump_taken(jump_taken),
    .halt_req(halt_req),
    .mem_read(mem_read),
    .ir_load(ir_load),
    .exec_start(exec_start),
    .exec_half(exec_half),
    .pc_inc(pc_inc),
    .halted(halted),
    .bus_error(bus_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check outputs clear at once, release and check boot delay
  task automatic boot();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    exec_done = 1'b0;
    jump_taken = 1'b0;
    halt_req = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=%b", outs, 7'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (mem_read !== 1'b0) begin
      bad++;
      $display("FAIL boot_idle got=%b want=0", mem_read);
    end
    step();
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL boot_fetch got=%b want=1", mem_read);
    end
  endtask

  // Drive one word from its first FETCH cycle; responder plus scoreboard
  task automatic run_word(input int rdy_dly, input bit sh, input bit nop,
                          input bit jmp, input bit hlt);
    int fc = 0;
    int nd = 0;
    int code;
    int e;
    int np;
    bit prev_start = 1'b0;
    bit loaded = 1'b0;
    bit fin = 1'b0;
    c_load = 0; c_start = 0; c_pc = 0; c_end = 0;
    n_start = 0; n_pc = 0;
    ir_short = sh;
    lo_nop = nop;
    for (int c = 1; c <= 300 && !fin; c++) begin
      np = int'(ir_load) + int'(exec_start) + int'(pc_inc);
      total++;
      if (np > 1) begin
        bad++;
        $display("FAIL pulse_onehot c=%0d got=%0d want<=1", c, np);
      end
      code = 0;
      if (ir_load) code = 1;
      else if (exec_start) code = exec_half ? 3 : 2;
      else if (pc_inc) code = 4;
      if (code != 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected c=%0d got=%0d want=none", c, code);
        end else begin
          e = exp_q.pop_front();
          if (e !== code) begin
            bad++;
            $display("FAIL sb_order c=%0d got=%0d want=%0d", c, code, e);
          end
        end
      end
      if (ir_load) begin
        loaded = 1'b1;
        if (c_load == 0) c_load = c;
      end
      if (exec_start) begin
        n_start++;
        if (c_start == 0) c_start = c;
      end
      if (pc_inc) begin
        n_pc++;
        c_pc = c;
      end
      if (halted || bus_error || (mem_read && loaded)) begin
        fin = 1'b1;
        c_end = c;
      end else begin
        mem_ready = 1'b0;
        exec_done = 1'b0;
        jump_taken = 1'b0;
        halt_req = 1'b0;
        if (mem_read) begin
          if (fc == rdy_dly) begin
            mem_ready = 1'b1;
            exp_q.push_back(1);
            exp_q.push_back(2);
          end
          fc++;
        end
        if (prev_start) begin
          exec_done = 1'b1;
          if (nd == 0) begin
            jump_taken = jmp;
            halt_req = hlt;
            if (!hlt && !jmp) exp_q.push_back((sh && !nop) ? 3 : 4);
          end else begin
            exp_q.push_back(4);
          end
          nd++;
        end
        prev_start = exec_start;
        step();
      end
    end
    mem_ready = 1'b0;
    exec_done = 1'b0;
    jump_taken = 1'b0;
    halt_req = 1'b0;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL word_timeout got=none want=end");
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    boot();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    total++;
    if (ir_load !== 1'b1) begin
      bad++;
      $display("FAIL load_before_rst got=%b want=1", ir_load);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_load got=%b want=%b", outs, 7'b0);
    end
    boot();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    total++;
    if (exec_start !== 1'b1) begin
      bad++;
      $display("FAIL issue_before_rst got=%b want=1", exec_start);
    end
    step();
    boot();
    run_word(0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (c_load !== 2) begin
      bad++;
      $display("FAIL post_rst_load got=%0d want=2", c_load);
    end
  endtask

  task automatic test_full_word();
    run_word(0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (c_load !== 2) begin
      bad++;
      $display("FAIL full_load_cyc got=%0d want=2", c_load);
    end
    total++;
    if (c_start !== 3) begin
      bad++;
      $display("FAIL full_start_cyc got=%0d want=3", c_start);
    end
    total++;
    if (c_pc !== 5) begin
      bad++;
      $display("FAIL full_pcinc_cyc got=%0d want=5", c_pc);
    end
    total++;
    if (c_end !== 6) begin
      bad++;
      $display("FAIL full_next_fetch got=%0d want=6", c_end);
    end
  endtask

  task automatic test_packed();
    run_word(0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (n_start !== 2 || n_pc !== 1) begin
      bad++;
      $display("FAIL packed_counts got=%0d/%0d want=2/1", n_start, n_pc);
    end
    total++;
    if (c_end !== 8) begin
      bad++;
      $display("FAIL packed_next_fetch got=%0d want=8", c_end);
    end
    run_word(0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (n_start !== 1 || n_pc !== 1) begin
      bad++;
      $display("FAIL lonop_counts got=%0d/%0d want=1/1", n_start, n_pc);
    end
  endtask

  task automatic test_jump();
    run_word(0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (n_start !== 1 || n_pc !== 0) begin
      bad++;
      $display("FAIL jump_counts got=%0d/%0d want=1/0", n_start, n_pc);
    end
    total++;
    if (c_end !== 5) begin
      bad++;
      $display("FAIL jump_next_fetch got=%0d want=5", c_end);
    end
  endtask

  task automatic test_back_to_back();
    bit sh, nop, jmp;
    int want_s;
    for (int w = 0; w < 8; w++) begin
      sh = 1'($urandom_range(0, 1));
      nop = 1'($urandom_range(0, 1));
      jmp = 1'($urandom_range(0, 3) == 0);
      want_s = (!jmp && sh && !nop) ? 2 : 1;
      run_word(int'($urandom_range(0, 3)), sh, nop, jmp, 1'b0);
      total++;
      if (n_start !== want_s || n_pc !== (jmp ? 0 : 1)) begin
        bad++;
        $display("FAIL b2b_counts w=%0d got=%0d/%0d want=%0d/%0d",
                 w, n_start, n_pc, want_s, jmp ? 0 : 1);
      end
    end
  endtask

  task automatic test_timeout();
    run_word(14, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (c_load !== 16 || bus_error !== 1'b0) begin
      bad++;
      $display("FAIL late_ready got=%0d/%b want=16/0", c_load, bus_error);
    end
    run_word(99, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus_error !== 1'b1 || c_end !== 16) begin
      bad++;
      $display("FAIL timeout got=%b@%0d want=1@16", bus_error, c_end);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({bus_error, mem_read, ir_load} !== 3'b100) begin
        bad++;
        $display("FAIL error_sticky i=%0d got=%b want=100", i,
                 {bus_error, mem_read, ir_load});
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_halt();
    run_word(0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (halted !== 1'b1 || c_end !== 5 || n_pc !== 0) begin
      bad++;
      $display("FAIL halt_entry got=%b@%0d pc=%0d want=1@5 pc=0",
               halted, c_end, n_pc);
    end
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({halted, mem_read, exec_start} !== 3'b100) begin
        bad++;
        $display("FAIL halt_sticky i=%0d got=%b want=100", i,
                 {halted, mem_read, exec_start});
      end
    end
    mem_ready = 1'b0;
    exec_done = 1'b0;
    boot();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_packed();
    test_jump();
    test_back_to_back();
    test_halt();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
